// File: rtl/decode_queue_if.sv
// Fetcher-side and dispatcher-side handshake bundle for decode_queue.
// The slave modport is the queue's view; master is the fetcher/dispatcher environment.
interface decode_queue_if #(
    parameter int OP_WIDTH = 7
);
    logic                inst_valid_in;
    logic                inst_ready_out;
    logic [31:0]         inst_in;
    logic [31:0]         pc_in;
    logic                out_valid;
    logic                out_ready;
    logic [OP_WIDTH-1:0] out_op_type;
    logic [5:0]          out_rd;
    logic [5:0]          out_rs1;
    logic [5:0]          out_rs2;
    logic [31:0]         out_imm;
    logic [31:0]         out_pc;
    logic                out_illegal;

    modport slave (
        input  inst_valid_in, inst_in, pc_in, out_ready,
        output inst_ready_out, out_valid, out_op_type, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_illegal
    );

    modport master (
        output inst_valid_in, inst_in, pc_in, out_ready,
        input  inst_ready_out, out_valid, out_op_type, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_illegal
    );
endinterface

// File: rtl/decode_queue.sv
// RV32I decoder feeding a 2^DEPTH_WIDTH entry FIFO drained by the dispatcher.
// DECODE_ILLEGAL_EN: enqueue unrecognised encodings flagged illegal instead of dropping them.
module decode_queue #(
    parameter int DEPTH_WIDTH = 2,
    parameter int OP_WIDTH    = 7
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          rdy_in,
    input  logic          flush_in,
    decode_queue_if.slave dq
);
    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] FULL = (DEPTH_WIDTH+1)'(DEPTH);

    typedef struct packed {
        logic [OP_WIDTH-1:0] op;
        logic [5:0]          rd;
        logic [5:0]          rs1;
        logic [5:0]          rs2;
        logic [31:0]         imm;
        logic [31:0]         pc;
        logic                illegal;
    } entry_t;

    entry_t                 mem [DEPTH];
    entry_t                 dec;
    entry_t                 head_e;
    logic [DEPTH_WIDTH-1:0] head, tail;
    logic [DEPTH_WIDTH:0]   count;

    logic [31:0] inst;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
    logic [5:0]  op_c;
    logic [31:0] imm_c;
    logic        rd_v, rs1_v, rs2_v, bad;
    logic        accept, store, pop;

    assign inst   = dq.inst_in;
    assign opc    = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_sh = {27'b0, inst[24:20]};

    always_comb begin
        op_c  = '0;
        imm_c = '0;
        rd_v  = 1'b0;
        rs1_v = 1'b0;
        rs2_v = 1'b0;
        bad   = 1'b0;
        case (opc)
            7'b0110111: begin op_c = 6'd1; rd_v = 1'b1; imm_c = imm_u; end
            7'b0010111: begin op_c = 6'd2; rd_v = 1'b1; imm_c = imm_u; end
            7'b1101111: begin op_c = 6'd3; rd_v = 1'b1; imm_c = imm_j; end
            7'b1100111: begin
                op_c = 6'd4; rd_v = 1'b1; rs1_v = 1'b1; imm_c = imm_i;
                bad  = (f3 != 3'd0);
            end
            7'b1100011: begin
                rs1_v = 1'b1; rs2_v = 1'b1; imm_c = imm_b;
                case (f3)
                    3'd0: op_c = 6'd5;
                    3'd1: op_c = 6'd6;
                    3'd4: op_c = 6'd7;
                    3'd5: op_c = 6'd8;
                    3'd6: op_c = 6'd9;
                    3'd7: op_c = 6'd10;
                    default: bad = 1'b1;
                endcase
            end
            7'b0000011: begin
                rd_v = 1'b1; rs1_v = 1'b1; imm_c = imm_i;
                case (f3)
                    3'd0: op_c = 6'd11;
                    3'd1: op_c = 6'd12;
                    3'd2: op_c = 6'd13;
                    3'd4: op_c = 6'd14;
                    3'd5: op_c = 6'd15;
                    default: bad = 1'b1;
                endcase
            end
            7'b0100011: begin
                rs1_v = 1'b1; rs2_v = 1'b1; imm_c = imm_s;
                case (f3)
                    3'd0: op_c = 6'd16;
                    3'd1: op_c = 6'd17;
                    3'd2: op_c = 6'd18;
                    default: bad = 1'b1;
                endcase
            end
            7'b0010011: begin
                rd_v = 1'b1; rs1_v = 1'b1; imm_c = imm_i;
                case (f3)
                    3'd0: op_c = 6'd19;
                    3'd2: op_c = 6'd20;
                    3'd3: op_c = 6'd21;
                    3'd4: op_c = 6'd22;
                    3'd6: op_c = 6'd23;
                    3'd7: op_c = 6'd24;
                    3'd1: begin op_c = 6'd25; imm_c = imm_sh; bad = (f7 != 7'd0); end
                    default: begin
                        op_c  = inst[30] ? 6'd27 : 6'd26;
                        imm_c = imm_sh;
                        bad   = (f7 != {1'b0, inst[30], 5'b0});
                    end
                endcase
            end
            7'b0110011: begin
                rd_v = 1'b1; rs1_v = 1'b1; rs2_v = 1'b1;
                // Only add/sub and srl/sra may carry funct7 = 0100000.
                case (f3)
                    3'd0: begin op_c = inst[30] ? 6'd29 : 6'd28; bad = (f7 != {1'b0, inst[30], 5'b0}); end
                    3'd5: begin op_c = inst[30] ? 6'd35 : 6'd34; bad = (f7 != {1'b0, inst[30], 5'b0}); end
                    3'd1: begin op_c = 6'd30; bad = (f7 != 7'd0); end
                    3'd2: begin op_c = 6'd31; bad = (f7 != 7'd0); end
                    3'd3: begin op_c = 6'd32; bad = (f7 != 7'd0); end
                    3'd4: begin op_c = 6'd33; bad = (f7 != 7'd0); end
                    3'd6: begin op_c = 6'd36; bad = (f7 != 7'd0); end
                    default: begin op_c = 6'd37; bad = (f7 != 7'd0); end
                endcase
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        dec.op  = bad ? '0 : OP_WIDTH'(op_c);
        dec.rd  = (!bad && rd_v && rd != 5'd0) ? {1'b1, rd} : 6'd0;
        dec.rs1 = (!bad && rs1_v) ? {1'b1, rs1} : 6'd0;
        dec.rs2 = (!bad && rs2_v) ? {1'b1, rs2} : 6'd0;
        dec.imm = bad ? 32'd0 : imm_c;
        dec.pc  = dq.pc_in;
`ifdef DECODE_ILLEGAL_EN
        dec.illegal = bad;
`else
        dec.illegal = 1'b0;
`endif
    end

    assign dq.inst_ready_out = rdy_in && !flush_in && (count != FULL);
    assign dq.out_valid      = rdy_in && (count != '0);
    assign accept            = dq.inst_valid_in && dq.inst_ready_out;
    assign pop               = dq.out_valid && dq.out_ready && !flush_in;
`ifdef DECODE_ILLEGAL_EN
    assign store = accept;
`else
    // Illegal encodings complete the handshake but are silently dropped.
    assign store = accept && !bad;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (store) begin
                    mem[tail] <= dec;
                    tail      <= tail + 1'b1;
                end
                if (pop) head <= head + 1'b1;
                case ({store, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Empty queue presents all-zero fields regardless of stale storage.
    assign head_e = (count != '0) ? mem[head] : '0;

    assign dq.out_op_type = head_e.op;
    assign dq.out_rd      = head_e.rd;
    assign dq.out_rs1     = head_e.rs1;
    assign dq.out_rs2     = head_e.rs2;
    assign dq.out_imm     = head_e.imm;
    assign dq.out_pc      = head_e.pc;
    assign dq.out_illegal = head_e.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode fields, FIFO order/wrap, full, flush, stall, illegal, reset.
module tb_decode_queue;
    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] BEQ  = 32'hFE000EE3;
    localparam logic [31:0] SRAI = 32'h40315093;
    localparam logic [31:0] LUI  = 32'h123450B7;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] ILL  = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic rst_n, rdy, flush;
    int   tests = 0;
    int   fails = 0;

    decode_queue_if #(.OP_WIDTH(7)) dq ();

    decode_queue #(.DEPTH_WIDTH(2), .OP_WIDTH(7)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .flush_in (flush),
        .dq       (dq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        dq.inst_valid_in = 1'b1;
        dq.inst_in       = i;
        dq.pc_in         = p;
        tick();
        dq.inst_valid_in = 1'b0;
    endtask

    task automatic pop1();
        dq.out_ready = 1'b1;
        tick();
        dq.out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
        dq.inst_valid_in = 1'b0; dq.inst_in = '0; dq.pc_in = '0; dq.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", dq.out_valid, 0);
        chk("rst_ready", dq.inst_ready_out, 1);
        chk("rst_op", dq.out_op_type, 0);
        chk("rst_pc", dq.out_pc, 0);
        chk("rst_imm", dq.out_imm, 0);
        chk("rst_illegal", dq.out_illegal, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // addi x1, x0, 5
        push(ADDI, 32'h100);
        chk("addi_valid", dq.out_valid, 1);
        chk("addi_op", dq.out_op_type, 19);
        chk("addi_rd", dq.out_rd, 32'h21);
        chk("addi_rs1", dq.out_rs1, 32'h20);
        chk("addi_rs2", dq.out_rs2, 0);
        chk("addi_imm", dq.out_imm, 5);
        chk("addi_pc", dq.out_pc, 32'h100);
        pop1();
        chk("empty_valid", dq.out_valid, 0);
        chk("empty_op", dq.out_op_type, 0);

        push(BEQ, 32'h104);
        chk("beq_op", dq.out_op_type, 5);
        chk("beq_imm", dq.out_imm, 32'hFFFFFFFC);
        chk("beq_rd", dq.out_rd, 0);
        chk("beq_rs2", dq.out_rs2, 32'h20);
        pop1();

        push(SRAI, 32'h108);
        chk("srai_op", dq.out_op_type, 27);
        chk("srai_imm", dq.out_imm, 3);
        chk("srai_rs1", dq.out_rs1, 32'h22);
        chk("srai_rs2", dq.out_rs2, 0);
        pop1();

        push(LUI, 32'h10C);
        chk("lui_op", dq.out_op_type, 1);
        chk("lui_imm", dq.out_imm, 32'h12345000);
        chk("lui_rd", dq.out_rd, 32'h21);
        chk("lui_rs1", dq.out_rs1, 0);
        pop1();

        // add x3, x1, x2 -- also leaves the pointers offset by one for wrap coverage
        push(ADD, 32'h110);
        chk("add_op", dq.out_op_type, 28);
        chk("add_rd", dq.out_rd, 32'h23);
        chk("add_rs1", dq.out_rs1, 32'h21);
        chk("add_rs2", dq.out_rs2, 32'h22);
        chk("add_imm", dq.out_imm, 0);
        pop1();

        // Fill and drain, twice so the circular pointers wrap
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 4; k++) begin
                chk("fill_ready", dq.inst_ready_out, 1);
                push(ADDI, 32'h200 + pass * 32'h100 + k * 4);
            end
            chk("full_ready", dq.inst_ready_out, 0);
            chk("full_valid", dq.out_valid, 1);
            push(ADDI, 32'hDEAD);
            dq.out_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                chk("drain_pc", dq.out_pc, 32'h200 + pass * 32'h100 + k * 4);
                tick();
                chk("drain_ready", dq.inst_ready_out, 1);
            end
            dq.out_ready = 1'b0;
            chk("drained_valid", dq.out_valid, 0);
        end

        // Valid and ready both held with the queue full
        for (int k = 0; k < 4; k++) push(ADDI, 32'h400 + k * 4);
        chk("cc_full_ready", dq.inst_ready_out, 0);
        dq.inst_valid_in = 1'b1; dq.inst_in = ADDI; dq.pc_in = 32'h410;
        dq.out_ready = 1'b1;
        tick();
        chk("cc_pc1", dq.out_pc, 32'h404);
        chk("cc_ready1", dq.inst_ready_out, 1);
        tick();
        chk("cc_pc2", dq.out_pc, 32'h408);
        dq.pc_in = 32'h414;
        tick();
        chk("cc_pc3", dq.out_pc, 32'h40C);
        chk("cc_ready3", dq.inst_ready_out, 1);
        dq.inst_valid_in = 1'b0;
        chk("cc_d0", dq.out_pc, 32'h40C); tick();
        chk("cc_d1", dq.out_pc, 32'h410); tick();
        chk("cc_d2", dq.out_pc, 32'h414); tick();
        chk("cc_empty", dq.out_valid, 0);
        dq.out_ready = 1'b0;

        // Flush with three queued and a same-cycle push
        for (int k = 0; k < 3; k++) push(ADDI, 32'h500 + k * 4);
        dq.inst_valid_in = 1'b1; dq.pc_in = 32'h50C; flush = 1'b1;
        #1;
        chk("flush_ready", dq.inst_ready_out, 0);
        tick();
        flush = 1'b0; dq.inst_valid_in = 1'b0;
        chk("flush_valid", dq.out_valid, 0);
        chk("flush_pc", dq.out_pc, 0);
        tick();
        chk("flush_lost", dq.out_valid, 0);

        // rdy_in low freezes everything
        push(ADDI, 32'h700);
        push(ADDI, 32'h704);
        rdy = 1'b0;
        #1;
        chk("stall_valid", dq.out_valid, 0);
        chk("stall_ready", dq.inst_ready_out, 0);
        dq.inst_valid_in = 1'b1; dq.pc_in = 32'h708; dq.out_ready = 1'b1;
        tick(); tick();
        dq.inst_valid_in = 1'b0; dq.out_ready = 1'b0;
        rdy = 1'b1;
        #1;
        chk("stall_head", dq.out_pc, 32'h700);
        pop1();
        chk("stall_next", dq.out_pc, 32'h704);
        pop1();
        chk("stall_empty", dq.out_valid, 0);

        // Illegal encoding behind a legal one
        push(ADDI, 32'h5F0);
        chk("ill_ready", dq.inst_ready_out, 1);
        push(ILL, 32'h600);
        chk("ill_head", dq.out_pc, 32'h5F0);
        pop1();
`ifdef DECODE_ILLEGAL_EN
        chk("ill_valid", dq.out_valid, 1);
        chk("ill_op", dq.out_op_type, 0);
        chk("ill_flag", dq.out_illegal, 1);
        chk("ill_pc", dq.out_pc, 32'h600);
        chk("ill_rd", dq.out_rd, 0);
        chk("ill_imm", dq.out_imm, 0);
        pop1();
`else
        chk("ill_dropped", dq.out_valid, 0);
        chk("ill_flag", dq.out_illegal, 0);
`endif
        chk("ill_empty", dq.out_valid, 0);

        // Asynchronous reset mid-stream
        push(LUI, 32'h800);
        push(ADDI, 32'h804);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", dq.out_valid, 0);
        chk("arst_pc", dq.out_pc, 0);
        chk("arst_imm", dq.out_imm, 0);
        chk("arst_op", dq.out_op_type, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_ready", dq.inst_ready_out, 1);
        chk("arst_still_empty", dq.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
